// File: rtl/capture_ctrl.sv
// Capture sequencer: gates ADC samples (or a counter test pattern) into
// fixed-size packets with TLAST, buffers them in a first-word-fall-through
// FIFO and presents them as an AXI4-Stream master to the DMA S2MM input.
module capture_ctrl #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SIZE_W     = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ctrl_start,
  input  logic              ctrl_test,
  input  logic [SIZE_W-1:0] pkt_size,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              busy,
  output logic              overflow,
  output logic [31:0]       pkt_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // FIFO storage and pointers; the head entry is mirrored in r_tdata/r_tlast
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];
  logic [AW-1:0]     r_rptr;
  logic [AW-1:0]     r_wptr;
  logic [CW-1:0]     r_count;
  logic              r_tvalid;
  logic              r_tlast;
  logic [DATA_W-1:0] r_tdata;

  // Sequencer state
  state_t            r_state;
  logic              r_busy;
  logic              r_overflow;
  logic [31:0]       r_pkt_count;
  logic [DATA_W-1:0] r_tcnt;
  logic [SIZE_W-1:0] r_in_idx;
  logic [SIZE_W-1:0] r_size;
  logic              r_start_d;

  logic              w_pop;
  logic              w_full;
  logic              w_room;
  logic              w_last_tag;
  logic              w_stop_idle;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic              w_start_rise;
  logic [DATA_W-1:0] w_push_data;
  logic [CW-1:0]     w_cnt_ap;
  logic [AW-1:0]     w_rptr_nxt;
  logic              w_head_vld;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_last;

  // A full FIFO still accepts a push when the head is leaving this cycle
  assign w_pop        = r_tvalid & m_axis_tready;
  assign w_full       = (r_count == CW'(FIFO_DEPTH));
  assign w_room       = ~w_full | w_pop;
  assign w_last_tag   = (r_in_idx == (r_size - SIZE_W'(1)));
  assign w_stop_idle  = (r_state == S_RUN) & ~ctrl_start & (r_in_idx == '0);
  assign w_push_req   = (r_state == S_RUN) & adc_valid & ~w_stop_idle;
  assign w_push       = w_push_req & w_room;
  assign w_drop       = w_push_req & ~w_room;
  assign w_start_rise = ctrl_start & ~r_start_d;
  assign w_push_data  = ctrl_test ? r_tcnt : adc_data;
  assign w_cnt_ap     = r_count - CW'(w_pop);
  assign w_rptr_nxt   = r_rptr + AW'(w_pop);

  // Next head of the FIFO: oldest stored entry, else the sample being pushed
  always_comb begin
    w_head_vld  = 1'b0;
    w_head_data = '0;
    w_head_last = 1'b0;
    if (w_cnt_ap != '0) begin
      w_head_vld  = 1'b1;
      w_head_data = r_mem_data[w_rptr_nxt];
      w_head_last = r_mem_last[w_rptr_nxt];
    end else if (w_push) begin
      w_head_vld  = 1'b1;
      w_head_data = w_push_data;
      w_head_last = w_last_tag;
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= w_push_data;
      r_mem_last[r_wptr] <= w_last_tag;
    end
  end

  // FIFO pointers, occupancy and registered stream outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_cnt_ap + CW'(w_push);
      r_tvalid <= w_head_vld;
      r_tdata  <= w_head_data;
      r_tlast  <= w_head_last;
    end
  end

  // Capture sequencer: IDLE -> RUN on a start edge, RUN -> DRAIN on a
  // packet boundary once start drops, DRAIN -> IDLE once the FIFO is empty
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_overflow  <= 1'b0;
      r_pkt_count <= '0;
      r_tcnt      <= '0;
      r_in_idx    <= '0;
      r_size      <= '0;
      r_start_d   <= 1'b0;
    end else begin
      r_start_d <= ctrl_start;
      if (w_pop && r_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start_rise && (pkt_size != '0)) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_size      <= pkt_size;
            r_overflow  <= 1'b0;
            r_pkt_count <= '0;
            r_in_idx    <= '0;
            r_tcnt      <= '0;
          end
        end
        S_RUN: begin
          if (w_stop_idle) begin
            r_state <= S_DRAIN;
          end else begin
            if (w_drop) begin
              r_overflow <= 1'b1;
            end
            if (w_push) begin
              r_tcnt   <= r_tcnt + DATA_W'(1);
              r_in_idx <= w_last_tag ? '0 : (r_in_idx + SIZE_W'(1));
              if (!ctrl_start && w_last_tag) begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (r_count == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign busy          = r_busy;
  assign overflow      = r_overflow;
  assign pkt_count     = r_pkt_count;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: expected beats are queued when
// samples are driven and compared as the stream handshakes them.
module tb_capture_ctrl;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SIZE_W     = 16;
  localparam int unsigned FIFO_DEPTH = 16;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              ctrl_start = 1'b0;
  logic              ctrl_test = 1'b0;
  logic [SIZE_W-1:0] pkt_size = '0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready = 1'b1;
  logic              busy;
  logic              overflow;
  logic [31:0]       pkt_count;

  capture_ctrl #(
    .DATA_W     (DATA_W),
    .SIZE_W     (SIZE_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ctrl_start    (ctrl_start),
    .ctrl_test     (ctrl_test),
    .pkt_size      (pkt_size),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy          (busy),
    .overflow      (overflow),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    int unsigned size;
    bit          test;
    int unsigned nsamp;
    bit          rnd;
    int unsigned exp_pkts;
    bit          exp_ovf;
  } vec_t;

  beat_t             sb[$];
  vec_t              vecs[4];
  int                n_vec = 0;
  int                n_err = 0;
  bit                rnd_rdy = 1'b0;
  bit                stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic              prev_last = 1'b0;
  int unsigned       m_idx = 0;
  int unsigned       m_size = 1;
  logic [DATA_W-1:0] m_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream monitor, sampled on the falling edge ahead of the handshake edge
  task automatic monitor();
    beat_t b;
    if (!resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("axis_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
              64'({1'b1, prev_last, prev_data}));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got tdata 0x%0h tlast %0b, expected no beat at %0t",
                   m_axis_tdata, m_axis_tlast, $time);
        end else begin
          b = sb.pop_front();
          check("beat", 64'({m_axis_tlast, m_axis_tdata}), 64'({b.last, b.data}));
        end
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rnd_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  // Drive one adc_valid strobe; queue the expected beat when it is accepted
  task automatic push(input logic [DATA_W-1:0] d, input bit acc);
    beat_t b;
    adc_valid = 1'b1;
    adc_data  = d;
    if (acc) begin
      b.data = ctrl_test ? m_cnt : d;
      b.last = (m_idx == m_size - 1);
      sb.push_back(b);
      m_cnt++;
      m_idx = b.last ? 0 : m_idx + 1;
    end
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic start_cap(input int unsigned size, input bit test);
    pkt_size   = SIZE_W'(size);
    ctrl_test  = test;
    ctrl_start = 1'b1;
    m_idx      = 0;
    m_cnt      = '0;
    m_size     = size;
    tick();
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick();
    end
    check(name, 64'(busy), 64'(0));
  endtask

  initial begin
    vecs[0] = '{32, 1'b1, 64,   1'b0, 2,   1'b0};
    vecs[1] = '{10, 1'b1, 1000, 1'b1, 100, 1'b0};
    vecs[2] = '{5,  1'b0, 15,   1'b0, 3,   1'b0};
    vecs[3] = '{1,  1'b1, 7,    1'b1, 7,   1'b0};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_pkt_count", 64'(pkt_count), 64'(0));
    resetn = 1'b1;
    repeat (2) tick();

    // Start edge with pkt_size 0 is ignored
    pkt_size   = '0;
    ctrl_start = 1'b1;
    repeat (2) tick();
    check("size0_busy", 64'(busy), 64'(0));
    ctrl_start = 1'b0;
    tick();

    // Single-sample latency into an empty FIFO
    m_axis_tready = 1'b1;
    start_cap(4, 1'b0);
    check("run_busy", 64'(busy), 64'(1));
    push(16'h1234, 1'b1);
    check("lat_tvalid", 64'(m_axis_tvalid), 64'(1));
    check("lat_tdata", 64'(m_axis_tdata), 64'h1234);
    for (int i = 0; i < 3; i++) push(16'($urandom), 1'b1);
    ctrl_start = 1'b0;
    wait_idle("lat_drain", 50);
    check("lat_pkts", 64'(pkt_count), 64'(1));

    // Overflow with the sink stalled, then resume
    start_cap(32, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 20; i++) push('0, i < 16);
    check("ovf_flag", 64'(overflow), 64'(1));
    m_axis_tready = 1'b1;
    repeat (20) tick();
    check("ovf_empty", 64'(m_axis_tvalid), 64'(0));
    push('0, 1'b1);
    for (int i = 0; i < 15; i++) push('0, 1'b1);
    ctrl_start = 1'b0;
    wait_idle("ovf_drain", 100);
    check("ovf_pkts", 64'(pkt_count), 64'(1));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Asynchronous reset in the middle of a packet
    start_cap(32, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 18; i++) push('0, i < 16);
    m_axis_tready = 1'b1;
    repeat (4) tick();
    resetn     = 1'b0;
    ctrl_start = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    sb.delete();
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("post_rst_ovf", 64'(overflow), 64'(0));
    check("post_rst_pkts", 64'(pkt_count), 64'(0));
    check("post_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    start_cap(32, 1'b1);
    push('0, 1'b1);
    check("restart_tvalid", 64'(m_axis_tvalid), 64'(1));
    check("restart_tdata", 64'(m_axis_tdata), 64'(0));
    for (int i = 0; i < 31; i++) push('0, 1'b1);
    ctrl_start = 1'b0;
    wait_idle("restart_drain", 100);
    check("restart_pkts", 64'(pkt_count), 64'(1));

    // Stop mid-packet finishes the packet; start during DRAIN is ignored
    start_cap(8, 1'b1);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 3; i++) push('0, 1'b1);
    ctrl_start = 1'b0;
    for (int i = 0; i < 5; i++) push('0, 1'b1);
    ctrl_start = 1'b1;
    repeat (2) tick();
    check("drain_busy", 64'(busy), 64'(1));
    m_axis_tready = 1'b1;
    wait_idle("stop_drain", 50);
    check("stop_pkts", 64'(pkt_count), 64'(1));
    repeat (3) tick();
    check("no_restart_busy", 64'(busy), 64'(0));
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
    repeat (3) tick();
    check("idle_no_beat", 64'(m_axis_tvalid), 64'(0));
    ctrl_start = 1'b0;
    tick();

    // Table-driven capture runs
    for (int v = 0; v < 4; v++) begin
      m_axis_tready = 1'b1;
      rnd_rdy       = vecs[v].rnd;
      start_cap(vecs[v].size, vecs[v].test);
      for (int s = 0; s < int'(vecs[v].nsamp); s++) begin
        push(16'($urandom), 1'b1);
        if (vecs[v].rnd) repeat (2) tick();
      end
      ctrl_start    = 1'b0;
      rnd_rdy       = 1'b0;
      m_axis_tready = 1'b1;
      wait_idle("vec_drain", 200);
      check("vec_pkts", 64'(pkt_count), 64'(vecs[v].exp_pkts));
      check("vec_ovf", 64'(overflow), 64'(vecs[v].exp_ovf));
      check("vec_tvalid", 64'(m_axis_tvalid), 64'(0));
      check("vec_sb_empty", 64'(sb.size()), 64'(0));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Capture sequencer between the ADC sample interface and the AXI DMA S2MM stream input of the digitizer.
- Controlled by the control register at 0x6000_0000 (bit0 start, bit1 test mode) and the packet-size register at 0x6000_0008.
- Gates ADC samples, or a counter test pattern, into packets of pkt_size samples with TLAST.
- Buffers them in a small FIFO and ends capture cleanly on a packet boundary.
- Reports status back to the register block.

Parameters:
DATA_W, 16, sample and TDATA width in bits
SIZE_W, 16, width of pkt_size (samples per packet)
FIFO_DEPTH, 16, output FIFO depth in samples (power of 2, >= 4)

Ports:
clk  in  1  system clock (FCLK domain); adc_valid already synchronized to it
resetn  in  1  asynchronous active-low reset
ctrl_start  in  1  capture enable level (control reg bit0)
ctrl_test  in  1  test-pattern mode (control reg bit1)
pkt_size  in  SIZE_W  samples per packet
adc_data  in  DATA_W  ADC sample
adc_valid  in  1  one-cycle sample strobe
m_axis_tdata  out  DATA_W  stream data to DMA
m_axis_tvalid  out  1  stream valid
m_axis_tlast  out  1  last sample of packet
m_axis_tready  in  1  DMA ready
busy  out  1  high when state != IDLE
overflow  out  1  sticky: sample dropped because FIFO full
pkt_count  out  32  completed packets (TLAST handshakes) since last start

Behaviour:
- Reset (async, resetn=0): state IDLE, FIFO emptied, tvalid=0, tlast=0, tdata=0, busy=0, overflow=0, pkt_count=0, test counter=0, in_idx=0. Takes effect immediately mid-packet; no partial packet resumes after reset.
- States:
  - IDLE: on rising edge of ctrl_start with pkt_size != 0 -> RUN. On entry to RUN: latch pkt_size into size_r, clear overflow, pkt_count, in_idx, test counter. Rising edge with pkt_size == 0 is ignored; stay IDLE.
  - RUN: each adc_valid pushes one sample.
    - Sample = test counter when ctrl_test=1, else adc_data. ctrl_test is sampled per push.
    - Test counter increments on every pushed sample and wraps at 2^DATA_W.
    - Push tag last = (in_idx == size_r-1); in_idx then wraps to 0, else increments.
    - If ctrl_start is low and the push is tagged last -> DRAIN.
    - If ctrl_start is low and in_idx == 0 (no partial packet) -> DRAIN without a push.
  - DRAIN: no pushes, adc_valid ignored. When FIFO empty and no beat pending -> IDLE.
- Overflow: adc_valid in RUN with FIFO full drops the sample and sets overflow. in_idx and test counter do not advance, so packet length is always exactly size_r delivered samples.
- Simultaneous push and pop on a full FIFO: pop frees the slot and the push is accepted; no overflow.
- FIFO is first-word-fall-through with registered write. adc_valid at cycle N -> m_axis_tvalid high at N+1 if the FIFO was empty.
- AXIS rules:
  - tdata and tlast stay stable while tvalid && !tready.
  - tvalid never drops without a handshake.
  - Throughput is 1 beat/cycle when tready=1.
- pkt_count increments on each tvalid && tready && tlast and wraps at 2^32.
- pkt_size changes during RUN/DRAIN have no effect until the next start.
- ctrl_start re-asserted during DRAIN is ignored. A new rising edge is required after IDLE.
- busy = (state != IDLE), registered.

Test Plan:
1. pkt_size=32, ctrl_test=1, start, tready=1, 64 adc_valid pulses, then clear start -> two packets with tdata 0..31 and 32..63, tlast on the 32nd and 64th beats, pkt_count=2, busy falls after the last beat, overflow=0.
2. Latency: empty FIFO, single adc_valid at cycle N -> tvalid=1 at N+1 with tdata=adc_data value 0x1234.
3. tready=0, 20 adc_valid pulses with FIFO_DEPTH=16 -> 16 stored, 4 dropped, overflow=1. Release tready -> 16 beats with consecutive test values 0..15; the next accepted sample is 16.
4. pkt_size=8, start cleared after the 3rd sample -> 5 more samples accepted, tlast on the 8th beat, then DRAIN -> IDLE. A further adc_valid in IDLE produces no beat.
5. Random tready backpressure (50%) over 1000 samples, pkt_size=10 -> every stalled beat holds tdata/tlast stable, no data loss, pkt_count=100.
6. resetn pulsed low mid-packet (beat 5 of 32) -> tvalid=0 and busy=0 immediately. Restart gives tdata 0 with the first beat, and pkt_count and overflow read 0.
